// File: rtl/nor_tree_pkg.sv
// Shared elaboration helpers and stage control typedef for the pipelined NOR/OR reducer.
package nor_tree_pkg;

  // Per-stage control word that travels down the pipe alongside the partial OR vector.
  typedef struct packed {
    logic valid;
    logic pol;
  } stage_ctrl_t;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Operand width rounded up to the next power of two; missing leaves are tied to 0.
  function automatic int unsigned pad_width(input int unsigned width);
    return 1 << clog2(width);
  endfunction

  // Number of registered stages; at least one even when no OR levels are needed.
  function automatic int unsigned num_stages(input int unsigned width,
                                             input int unsigned lps);
    int unsigned l;
    l = clog2(width);
    if (l == 0) return 1;
    return (l + lps - 1) / lps;
  endfunction

  // OR levels performed by stage k; the last stage may take fewer than lps.
  function automatic int unsigned stage_levels(input int unsigned width,
                                               input int unsigned lps,
                                               input int unsigned k);
    int unsigned l;
    int unsigned done;
    int unsigned rem;
    l    = clog2(width);
    done = k * lps;
    if (done >= l) return 0;
    rem = l - done;
    return (rem < lps) ? rem : lps;
  endfunction

  // Per-channel vector width entering stage k.
  function automatic int unsigned stage_in_width(input int unsigned width,
                                                 input int unsigned lps,
                                                 input int unsigned k);
    return pad_width(width) >> (k * lps);
  endfunction

endpackage

// File: rtl/nor_tree_stage.sv
// One registered slice of the OR tree: LEVELS pairwise OR levels per channel followed by a
// valid/ready register that carries the reduced vector and the transaction's polarity bit.
module nor_tree_stage
  import nor_tree_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 4,
  parameter int unsigned LEVELS    = 2,
  parameter int unsigned CHANNELS  = 1,
  localparam int unsigned OUT_WIDTH = IN_WIDTH >> LEVELS
) (
  input  logic                          ck,
  input  logic                          rst,
  input  logic                          up_valid,
  output logic                          up_ready,
  input  logic                          up_pol,
  input  logic [CHANNELS*IN_WIDTH-1:0]  up_data,
  output logic                          dn_valid,
  input  logic                          dn_ready,
  output logic                          dn_pol,
  output logic [CHANNELS*OUT_WIDTH-1:0] dn_data
);

  logic [CHANNELS*OUT_WIDTH-1:0] reduced;
  stage_ctrl_t                   ctrl_q, ctrl_d;
  logic [CHANNELS*OUT_WIDTH-1:0] data_q, data_d;
  logic                          load;

  // Each level halves the vector; every level gets its own exactly-sized net.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    for (genvar lv = 0; lv <= LEVELS; lv++) begin : g_lv
      logic [(IN_WIDTH >> lv)-1:0] v;
      if (lv == 0) begin : g_leaf
        assign v = up_data[c*IN_WIDTH +: IN_WIDTH];
      end else begin : g_pair
        for (genvar j = 0; j < (IN_WIDTH >> lv); j++) begin : g_or
          assign v[j] = g_lv[lv-1].v[2*j] | g_lv[lv-1].v[2*j+1];
        end
      end
    end
    assign reduced[c*OUT_WIDTH +: OUT_WIDTH] = g_lv[LEVELS].v;
  end

  // The slot is free when empty or when its current content leaves this cycle.
  assign up_ready = ~ctrl_q.valid | dn_ready;
  assign load     = up_valid & up_ready;

  // Next state: capture on a transfer in, otherwise empty the slot once downstream takes it.
  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (load) begin
      ctrl_d.valid = 1'b1;
      ctrl_d.pol   = up_pol;
      data_d       = reduced;
    end else if (dn_ready) begin
      ctrl_d.valid = 1'b0;
    end
  end

  // Stage register with synchronous reset of both control and data.
  always_ff @(posedge ck) begin
    if (rst) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign dn_valid = ctrl_q.valid;
  assign dn_pol   = ctrl_q.pol;
  assign dn_data  = data_q;

endmodule

// File: rtl/nor_tree_pipe.sv
// Pipelined wide NOR/OR reducer: CHANNELS lanes of WIDTH bits each, reduced through a chain of
// registered OR-tree stages sharing one valid/ready handshake. pol selects NOR (0) or OR (1).
module nor_tree_pipe
  import nor_tree_pkg::*;
#(
  parameter int unsigned WIDTH            = 8,
  parameter int unsigned CHANNELS         = 1,
  parameter int unsigned LEVELS_PER_STAGE = 2
) (
  input  logic                      ck,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] i,
  input  logic                      pol,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS-1:0]       nq
);

  localparam int unsigned PadWidth  = pad_width(WIDTH);
  localparam int unsigned NumStages = num_stages(WIDTH, LEVELS_PER_STAGE);
  localparam int unsigned Last      = NumStages - 1;

  // Handshake chain: index k is the boundary feeding stage k; index NumStages is the output.
  logic [NumStages:0] valid_chain;
  logic [NumStages:0] ready_chain;
  logic [NumStages:0] pol_chain;

  logic [CHANNELS*PadWidth-1:0] padded;
  logic [CHANNELS-1:0]          tail_or;

  // Zero-pad each lane up to a power of two; 0 leaves the OR result unchanged.
  always_comb begin
    padded = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      padded[c*PadWidth +: WIDTH] = i[c*WIDTH +: WIDTH];
    end
  end

  assign valid_chain[0]         = in_valid;
  assign pol_chain[0]           = pol;
  assign ready_chain[NumStages] = out_ready;

  for (genvar k = 0; k < NumStages; k++) begin : g_stage
    localparam int unsigned InW  = stage_in_width(WIDTH, LEVELS_PER_STAGE, k);
    localparam int unsigned Lv   = stage_levels(WIDTH, LEVELS_PER_STAGE, k);
    localparam int unsigned OutW = InW >> Lv;

    logic [CHANNELS*InW-1:0]  up_data;
    logic [CHANNELS*OutW-1:0] dn_data;

    if (k == 0) begin : g_head
      assign up_data = padded;
    end else begin : g_body
      assign up_data = g_stage[k-1].dn_data;
    end

    nor_tree_stage #(
      .IN_WIDTH (InW),
      .LEVELS   (Lv),
      .CHANNELS (CHANNELS)
    ) u_stage (
      .ck       (ck),
      .rst      (rst),
      .up_valid (valid_chain[k]),
      .up_ready (ready_chain[k]),
      .up_pol   (pol_chain[k]),
      .up_data  (up_data),
      .dn_valid (valid_chain[k+1]),
      .dn_ready (ready_chain[k+1]),
      .dn_pol   (pol_chain[k+1]),
      .dn_data  (dn_data)
    );
  end

  assign tail_or   = g_stage[Last].dn_data;
  assign out_valid = valid_chain[NumStages];
  // Reads 1 during reset even if the pipe was full; the reset itself blocks the capture.
  assign in_ready  = rst | ready_chain[0];

  // Final polarity: nq = ~(or ^ pol), forced to 0 whenever no result is presented.
  always_comb begin
    nq = '0;
    if (out_valid) begin
      nq = ~(tail_or ^ {CHANNELS{pol_chain[NumStages]}});
    end
  end

endmodule

// File: tb/tb_nor_tree_pipe.sv
// Scoreboard bench: two nor_tree_pipe instances (8-bit x2 lanes, and 5-bit padded x1 lane)
// share the handshake controls; expected results are queued at acceptance and popped by monitors.
module tb_nor_tree_pipe;

  localparam int unsigned AW = 8;
  localparam int unsigned AC = 2;
  localparam int unsigned BW = 5;

  logic ck        = 1'b0;
  logic rst       = 1'b1;
  logic in_valid  = 1'b0;
  logic out_ready = 1'b0;
  logic pol       = 1'b0;

  logic [AC*AW-1:0] a_i = '0;
  logic             a_in_ready;
  logic             a_out_valid;
  logic [AC-1:0]    a_nq;

  logic [BW-1:0]    b_i = '0;
  logic             b_in_ready;
  logic             b_out_valid;
  logic [0:0]       b_nq;

  int n_vec  = 0;
  int n_fail = 0;
  int a_acc  = 0;

  logic [AC-1:0] a_q[$];
  logic          b_q[$];

  always #5 ck = ~ck;

  nor_tree_pipe #(
    .WIDTH            (AW),
    .CHANNELS         (AC),
    .LEVELS_PER_STAGE (2)
  ) u_dut_a (
    .ck        (ck),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (a_in_ready),
    .i         (a_i),
    .pol       (pol),
    .out_valid (a_out_valid),
    .out_ready (out_ready),
    .nq        (a_nq)
  );

  nor_tree_pipe #(
    .WIDTH            (BW),
    .CHANNELS         (1),
    .LEVELS_PER_STAGE (2)
  ) u_dut_b (
    .ck        (ck),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (b_in_ready),
    .i         (b_i),
    .pol       (pol),
    .out_valid (b_out_valid),
    .out_ready (out_ready),
    .nq        (b_nq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a lane's result is "lane is zero" for pol=0, "lane is nonzero" for pol=1.
  function automatic logic [AC-1:0] model_a(input logic [AC*AW-1:0] d, input logic p);
    logic [AC-1:0] r;
    int unsigned   lane;
    r = '0;
    for (int c = 0; c < int'(AC); c++) begin
      lane = (32'(d) >> (c * AW)) % (1 << AW);
      r[c] = p ? (lane != 0) : (lane == 0);
    end
    return r;
  endfunction

  function automatic logic model_b(input logic [BW-1:0] d, input logic p);
    int unsigned lane;
    lane = 32'(d);
    return p ? (lane != 0) : (lane == 0);
  endfunction

  // Lane values biased towards zero and single-bit patterns so both results occur often.
  function automatic logic [7:0] rand_lane(input int unsigned w);
    int unsigned s;
    int unsigned v;
    s = $urandom_range(0, 3);
    if (s == 0) v = 0;
    else if (s == 1) v = 1 << $urandom_range(0, w - 1);
    else v = $urandom;
    v = v % (1 << w);
    return 8'(v);
  endfunction

  task automatic step(input logic v, input logic [AC*AW-1:0] ad, input logic [BW-1:0] bd,
                      input logic p, input logic ordy);
    @(negedge ck);
    in_valid  = v;
    a_i       = ad;
    b_i       = bd;
    pol       = p;
    out_ready = ordy;
    #1;
    if (!rst) begin
      if (v && a_in_ready) begin
        a_q.push_back(model_a(ad, p));
        a_acc++;
      end
      if (v && b_in_ready) b_q.push_back(model_b(bd, p));
    end
  endtask

  task automatic do_reset();
    @(negedge ck);
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    a_i       = '1;
    b_i       = '1;
    pol       = 1'b0;
    #1;
    chk("rst_in_ready_a", 32'(a_in_ready), 1);
    chk("rst_in_ready_b", 32'(b_in_ready), 1);
    a_q.delete();
    b_q.delete();
    @(negedge ck);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_rst_valid_a", 32'(a_out_valid), 0);
    chk("post_rst_nq_a", 32'(a_nq), 0);
    chk("post_rst_ready_a", 32'(a_in_ready), 1);
    chk("post_rst_valid_b", 32'(b_out_valid), 0);
    chk("post_rst_nq_b", 32'(b_nq), 0);
    chk("post_rst_ready_b", 32'(b_in_ready), 1);
  endtask

  // Monitor A: compare on each output transfer, hold-check during stalls, idle nq must be 0.
  logic          a_hold    = 1'b0;
  logic [AC-1:0] a_hold_nq = '0;
  always @(negedge ck) begin
    #2;
    if (rst) begin
      a_hold = 1'b0;
    end else begin
      if (a_hold) begin
        chk("a_stall_valid", 32'(a_out_valid), 1);
        chk("a_stall_nq", 32'(a_nq), 32'(a_hold_nq));
      end
      if (!a_out_valid) begin
        chk("a_idle_nq", 32'(a_nq), 0);
      end else if (out_ready) begin
        if (a_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL a_unexpected: got nq %0h with nothing pending, want no output", a_nq);
        end else begin
          chk("a_nq", 32'(a_nq), 32'(a_q.pop_front()));
        end
      end
      a_hold    = a_out_valid && !out_ready;
      a_hold_nq = a_nq;
    end
  end

  // Monitor B: same checks for the padded single-lane instance.
  logic       b_hold    = 1'b0;
  logic [0:0] b_hold_nq = '0;
  always @(negedge ck) begin
    #2;
    if (rst) begin
      b_hold = 1'b0;
    end else begin
      if (b_hold) begin
        chk("b_stall_valid", 32'(b_out_valid), 1);
        chk("b_stall_nq", 32'(b_nq), 32'(b_hold_nq));
      end
      if (!b_out_valid) begin
        chk("b_idle_nq", 32'(b_nq), 0);
      end else if (out_ready) begin
        if (b_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL b_unexpected: got nq %0h with nothing pending, want no output", b_nq);
        end else begin
          chk("b_nq", 32'(b_nq), 32'(b_q.pop_front()));
        end
      end
      b_hold    = b_out_valid && !out_ready;
      b_hold_nq = b_nq;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run by %0t, want completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc0;
    do_reset();

    // Single transaction: two-stage latency, nq = 2'b10 for lane 0 nonzero / lane 1 zero.
    step(1'b1, 16'h0080, 5'b10000, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    chk("lat_early_a", 32'(a_out_valid), 0);
    chk("lat_early_b", 32'(b_out_valid), 0);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    chk("lat_due_a", 32'(a_out_valid), 1);
    chk("lat_due_b", 32'(b_out_valid), 1);
    chk("lat_nq_a", 32'(a_nq), 32'h2);
    repeat (2) step(1'b0, '0, '0, 1'b0, 1'b1);

    // Six back-to-back beats with no backpressure.
    for (int k = 0; k < 6; k++) begin
      step(1'b1, {rand_lane(AW), rand_lane(AW)}, 5'(rand_lane(BW)), 1'($urandom_range(0, 1)),
           1'b1);
      chk("stream_ready_a", 32'(a_in_ready), 1);
      chk("stream_ready_b", 32'(b_in_ready), 1);
    end
    step(1'b0, '0, '0, 1'b0, 1'b1);
    chk("stream_tail_a", 32'(a_out_valid), 1);
    repeat (3) step(1'b0, '0, '0, 1'b0, 1'b1);

    // Backpressure: only two beats fit, then simultaneous fill and drain when released.
    acc0 = a_acc;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, {rand_lane(AW), rand_lane(AW)}, 5'(rand_lane(BW)), 1'($urandom_range(0, 1)),
           1'b0);
      if (k >= 2) begin
        chk("bp_ready_a", 32'(a_in_ready), 0);
        chk("bp_ready_b", 32'(b_in_ready), 0);
      end
    end
    chk("bp_accepts_a", 32'(a_acc - acc0), 2);
    step(1'b1, {rand_lane(AW), rand_lane(AW)}, 5'(rand_lane(BW)), 1'b1, 1'b1);
    chk("full_drain_ready_a", 32'(a_in_ready), 1);
    repeat (4) step(1'b0, '0, '0, 1'b0, 1'b1);

    // Padding on the 5-bit lane, then per-beat polarity with all-zero operands.
    step(1'b1, 16'h0000, 5'b10000, 1'b0, 1'b1);
    step(1'b1, 16'h0100, 5'b00000, 1'b0, 1'b1);
    step(1'b1, 16'h0000, 5'b00000, 1'b0, 1'b1);
    step(1'b1, 16'h0000, 5'b00000, 1'b1, 1'b1);
    step(1'b1, 16'h0000, 5'b00000, 1'b0, 1'b1);
    repeat (4) step(1'b0, '0, '0, 1'b0, 1'b1);

    // Fill the pipe, reset, and make sure nothing in flight ever appears.
    step(1'b1, 16'h0000, 5'b00000, 1'b0, 1'b0);
    step(1'b1, 16'h00FF, 5'b00001, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("full_valid_a", 32'(a_out_valid), 1);
    do_reset();
    repeat (4) step(1'b0, '0, '0, 1'b0, 1'b1);

    // Random traffic with random backpressure and the occasional reset.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 3) != 0), {rand_lane(AW), rand_lane(AW)},
             5'(rand_lane(BW)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7));
      end
    end

    for (int k = 0; k < 20 && (a_q.size() != 0 || b_q.size() != 0); k++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
    end
    step(1'b0, '0, '0, 1'b0, 1'b1);
    #2;
    chk("drain_empty_a", 32'(a_q.size()), 0);
    chk("drain_empty_b", 32'(b_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/nor_tree_pipe.md
Name: nor_tree_pipe

Overview:
Parametrised, pipelined wide NOR reducer. It is the sequential successor to the two-input NOR cell in the gf180mcu_c4m 9-track cell family. Each of CHANNELS lanes reduces a WIDTH-bit vector to one bit, computed as NOR or as OR depending on a per-transaction polarity bit. The reduction tree is split into registered stages with a valid/ready handshake, and the block sits in datapaths that need wide zero-detect at cell-library timing.

Parameters:
WIDTH, 8, input bits per channel; minimum 1.
CHANNELS, 1, independent reduction lanes sharing one handshake; minimum 1.
LEVELS_PER_STAGE, 2, two-input tree levels between pipeline registers; minimum 1.

Ports:
ck  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; synchronous, active-high.
in_valid  input  1  upstream presents a transaction.
in_ready  output  1  block accepts the transaction this cycle.
i  input  CHANNELS*WIDTH  operand bits; channel c occupies bits [c*WIDTH +: WIDTH].
pol  input  1  0 means nq = NOR(i_c); 1 means nq = OR(i_c); captured with the transaction.
out_valid  output  1  result available.
out_ready  input  1  downstream accepts the result.
nq  output  CHANNELS  result bit per channel.

Behaviour:
- Depth: L = ceil(log2(WIDTH)), with L = 0 when WIDTH = 1. Stage count S = max(1, ceil(L / LEVELS_PER_STAGE)).
- Latency: a transaction accepted at edge t appears on out_valid/nq after edge t+S-1 when the pipe is unstalled. Total latency is S cycles from acceptance to output.
- Tree:
  - Each channel ORs its bits pairwise, one level per tree level.
  - Odd or non-power-of-2 widths are zero-padded; 0 is the OR identity.
  - The final stage applies the inversion: nq_c = ~(OR_c ^ pol).
- Tree structure and pol:
  - The structure is fixed at elaboration; no runtime width select.
  - pol travels down the pipe with the data, so a pol change never affects transactions already in flight.
- Stage registers: each stage holds valid_k plus partial OR vectors and pol.
  - Stage k advances when valid_{k-1} is high and (valid_k is low or stage k is advancing).
  - The last stage advances when out_ready is high.
- in_ready = ~valid_0 | advance_0. The ready chain is combinational from out_ready. A transfer occurs when in_valid and in_ready are both high.
- Stall: while out_valid is high and out_ready is low, nq and out_valid hold stable. No bubble is inserted; the pipe holds up to S transactions.
- Throughput: one transaction per cycle while out_ready stays high.
- No reordering, no dropping, no duplication. Data registers of an invalid stage are don't-care internally, but nq must read 0 when out_valid is 0.
- Reset:
  - All valid_k and all data registers clear to 0.
  - Outputs after reset: out_valid = 0, nq = 0, in_ready = 1.
  - Reset mid-operation discards every in-flight transaction. A transaction presented in the reset cycle is not accepted, although in_ready reads 1 that cycle.
- Simultaneous fill and drain: when the pipe is full and out_ready is high, a new input is accepted in the same cycle the oldest result leaves.
- Degenerate case, WIDTH = 1: S = 1 and nq = ~(i ^ pol), registered.

Decomposition:
- Shared package nor_tree_pkg holds:
  - the clog2 function;
  - the stage-count function (WIDTH, LEVELS_PER_STAGE to S);
  - the padded-width function (next power of two);
  - the stage payload typedef (valid, pol, partial vector).
- Sub-module nor_tree_stage: one registered stage.
  - Parameters: input width, levels.
  - It performs LEVELS_PER_STAGE OR levels plus the valid/ready register slice.
- The top instantiates S stages via generate and applies the final inversion and polarity in the last stage.

Test Plan:
- WIDTH=8, CHANNELS=2, LEVELS_PER_STAGE=2 (S=2), pol=0, i=16'h0080, out_ready=1 -> two cycles later out_valid=1, nq=2'b10 (channel 0 nonzero, channel 1 zero).
- Same configuration, stream of 6 back-to-back inputs with out_ready=1 -> 6 consecutive out_valid cycles, results in order, in_ready constantly 1.
- Backpressure: out_ready=0 for 4 cycles while in_valid=1 -> in_ready drops after 2 accepts; nq/out_valid stable during the stall; all results delivered in order after out_ready=1.
- WIDTH=5 (S=2), pol=0: i=5'b10000 -> nq=0; i=5'b00000 -> nq=1. Padding must not force a 1.
- pol toggled per beat (0,1,0) with i=0 on every beat -> nq sequence 1,0,1, showing pol is captured per transaction.
- Pipe full with out_valid=1, then rst=1 for one cycle -> next cycle out_valid=0, nq=0, in_ready=1; in-flight results never appear.
